div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider that sequences DIV/DIVU for the MIPS core.
- Sits in the EXE stage. It raises a stall to the hazard unit while iterating.
- When done, it delivers quotient (LO) and remainder (HI) for one cycle. The HI/LO register is written in that cycle under the decoder's HLwrite.
- Supports flush (annul) mid-operation and a divide-by-zero fast path.

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 155 +++++++++++++++
 tb/tb_div_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encodings and result-valid constants for the
// multi-cycle divider.
`default_nettype none

package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE = 2'd0,
    DIV_ON   = 2'd1,
    DIV_END  = 2'd2
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on {rem,quo}.
// Rev 1.0
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_upper;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  assign w_upper = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_upper - {1'b0, i_divisor};
  // rem < divisor on entry keeps w_upper < 2*divisor, so the MSB is a clean borrow
  assign w_fits  = ~w_diff[WIDTH];

  assign o_rem = w_fits ? w_diff[WIDTH-1:0] : w_upper[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU with flush
// and divide-by-zero fast path. Rev 1.0
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_signed;
  logic             r_a_sign;
  logic             r_b_sign;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic             w_start_ok;
  logic             w_dbz;
  logic             w_last;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_start_ok = start & ~annul;
  assign w_dbz      = (divisor == '0);
  assign w_last     = (r_cnt == LAST);
  assign w_a_neg    = signed_div & dividend[WIDTH-1];
  assign w_b_neg    = signed_div & divisor[WIDTH-1];
  assign w_a_mag    = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag    = w_b_neg ? (~divisor + 1'b1) : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  // Sign correction is folded into the final iteration edge.
  assign w_quo_fix = (r_signed & (r_a_sign ^ r_b_sign)) ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_rem_fix = (r_signed & r_a_sign) ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= DIV_FREE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    ready       = DIV_RESULT_NOT_READY;
    case (r_state)
      DIV_FREE: begin
        if (w_start_ok) begin
          stall       = 1'b1;
          w_state_nxt = w_dbz ? DIV_END : DIV_ON;
        end
      end
      DIV_ON: begin
        stall = 1'b1;
        if (annul) begin
          w_state_nxt = DIV_FREE;
        end else if (w_last) begin
          w_state_nxt = DIV_END;
        end
      end
      DIV_END: begin
        ready       = DIV_RESULT_READY;
        w_state_nxt = DIV_FREE;
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_signed <= 1'b0;
      r_a_sign <= 1'b0;
      r_b_sign <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
    end else begin
      case (r_state)
        DIV_FREE: begin
          if (w_start_ok) begin
            if (w_dbz) begin
              r_lo <= '1;
              r_hi <= dividend;
            end else begin
              r_rem    <= '0;
              r_quo    <= w_a_mag;
              r_dvs    <= w_b_mag;
              r_signed <= signed_div;
              r_a_sign <= dividend[WIDTH-1];
              r_b_sign <= divisor[WIDTH-1];
              r_cnt    <= '0;
            end
          end
        end
        DIV_ON: begin
          if (!annul) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result_lo = r_lo;
  assign result_hi = r_hi;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed DIV/DIVU vectors.
`default_nettype none

module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        stall;
  logic        ready;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  typedef struct {
    int          cyc;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .annul      (annul),
    .stall      (stall),
    .ready      (ready),
    .result_lo  (result_lo),
    .result_hi  (result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (resetn && ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 required=0 lo=%h hi=%h (cycle %0d)",
                 result_lo, result_hi, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("result_lo", {32'd0, result_lo}, {32'd0, mon_e.lo});
        chk("result_hi", {32'd0, result_hi}, {32'd0, mon_e.hi});
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after ready.
  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi);
    int lat;
    int n;
    bit seen;
    lat  = (b == 32'd0) ? 1 : 33;
    n    = 0;
    seen = 0;
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    sb.push_back('{cyc + lat, elo, ehi});
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (stall) n++;
      if (ready) begin
        seen  = 1;
        start = 1'b0;
      end
    end
    chk("ready_seen", 64'(seen), 64'd1);
    chk("stall_cycles", 64'(n), 64'(lat));
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output bit seen);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  c0;
    bit  seen;
    resetn     = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    dividend   = '0;
    divisor    = '0;
    annul      = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_lo", {32'd0, result_lo}, 64'd0);
    chk("rst_hi", {32'd0, result_hi}, 64'd0);
    @(posedge clk); #1;

    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    do_div(1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);
    do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);

    // Annul mid-iteration, then a fresh divide two cycles later.
    signed_div = 1'b0;
    dividend   = 32'd1000;
    divisor    = 32'd3;
    start      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    chk("annul_stall_drop", 64'(stall), 64'd0);
    @(posedge clk); #1;
    do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // start with new operands while busy must not disturb the result.
    signed_div = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    start      = 1'b1;
    c0 = cyc;
    sb.push_back('{c0 + 33, 32'd14, 32'd2});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ready(seen);
    chk("busy_ready_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an operation.
    signed_div = 1'b0;
    dividend   = 32'hFFFF_FFFF;
    divisor    = 32'd3;
    start      = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    resetn = 1'b0;
    start  = 1'b0;
    #1;
    chk("async_rst_stall", 64'(stall), 64'd0);
    chk("async_rst_ready", 64'(ready), 64'd0);
    chk("async_rst_lo", {32'd0, result_lo}, 64'd0);
    chk("async_rst_hi", {32'd0, result_hi}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 64'(stall), 64'd0);
    chk("post_rst_ready", 64'(ready), 64'd0);
    chk("post_rst_lo", {32'd0, result_lo}, 64'd0);
    @(posedge clk); #1;
    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
